hilo_mult_seq: RTL and testbench

Multi-cycle multiply sequencer that owns the HI/LO register pair in the pipelined MIPS core. It accepts MULT/MULTU from EX, runs a radix-2 shift-add over WIDTH cycles, and commits the 2*WIDTH product to HI/LO. It raises a pipeline stall when MFHI/MFLO or a second multiply arrives while the unit is busy. It sits beside the ALU and drives the HI/LO inputs of the writeback mux selected by the control unit's Jal_Mult_DM.

---
 rtl/mips_pkg.sv | 32 +++
 rtl/mult_datapath.sv | 69 ++++++
 rtl/hilo_mult_seq.sv | 110 +++++++++++
 tb/tb_hilo_mult_seq.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: multiply sequencer state encoding,
// default widths and the opcode/funct codes of the HI/LO instructions.
package mips_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } mult_state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;

  function automatic logic is_mul_fn(
    input logic [5:0] fn
  );
    return (fn == FN_MULT) || (fn == FN_MULTU);
  endfunction

  function automatic logic is_mf_fn(
    input logic [5:0] fn
  );
    return (fn == FN_MFHI) || (fn == FN_MFLO);
  endfunction

endpackage

// File: rtl/mult_datapath.sv
// Radix-2 shift-add multiplier datapath: operand magnitudes, accumulator, sign fix.
// Ports: clk/rst, i_load (latch operands), i_step (one iteration), i_sgn/i_a/i_b, o_result_nxt.
module mult_datapath
  import mips_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_step,
  input  logic               i_sgn,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_result_nxt
);

  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_prod;
  logic               r_neg;

  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic               w_neg;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_prod_nxt;

  // The most-negative operand negates to itself, which read
  // as unsigned is exactly its magnitude.
  always_comb begin
    w_a_mag = (i_sgn & i_a[WIDTH-1]) ? -i_a : i_a;
    w_b_mag = (i_sgn & i_b[WIDTH-1]) ? -i_b : i_b;
    w_neg   = i_sgn & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
  end

  // The carry out of the upper-half add is the accumulator's
  // extra bit; it lands in the MSB after the right shift.
  always_comb begin
    w_addend   = r_mplier[0] ? r_mcand : '0;
    w_sum      = {1'b0, r_prod[2*WIDTH-1:WIDTH]}
               + {1'b0, w_addend};
    w_prod_nxt = {w_sum, r_prod[WIDTH-1:1]};
  end

  // Valid on the final iteration; sign applied to the full product.
  always_comb begin
    o_result_nxt = r_neg ? -w_prod_nxt : w_prod_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_neg    <= 1'b0;
    end else if (i_load) begin
      r_mcand  <= w_a_mag;
      r_mplier <= w_b_mag;
      r_prod   <= '0;
      r_neg    <= w_neg;
    end else if (i_step) begin
      r_prod   <= w_prod_nxt;
      r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/hilo_mult_seq.sv
// Multi-cycle MULT/MULTU sequencer owning HI/LO; stalls on HI/LO access while busy.
// Ports: clk/rst, start/sgn/a/b, hilo_rd, flush; busy, stall, done, hi, lo.
module hilo_mult_seq
  import mips_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hilo_rd,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mult_state_t        r_state;
  mult_state_t        w_state_nxt;
  logic [CNT_W-1:0]   r_count;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_run;
  logic               w_accept;
  logic               w_step;
  logic               w_last;
  logic               w_commit;
  logic [2*WIDTH-1:0] w_result;

  assign w_run    = (r_state == S_RUN);
  assign w_accept = ~w_run & start & ~flush;
  assign w_step   = w_run & ~flush;
  assign w_last   = (r_count == CNT_W'(WIDTH - 1));
  assign w_commit = w_step & w_last;

  mult_datapath #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk          (clk),
    .rst          (rst),
    .i_load       (w_accept),
    .i_step       (w_step),
    .i_sgn        (sgn),
    .i_a          (a),
    .i_b          (b),
    .o_result_nxt (w_result)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (1'b1)
      (r_state == S_RUN): begin
        if (flush) begin
          w_state_nxt = S_IDLE;
        end else if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      (r_state == S_DONE): begin
        w_state_nxt = w_accept ? S_RUN : S_IDLE;
      end
      default: begin
        w_state_nxt = w_accept ? S_RUN : S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (w_accept) begin
      r_count <= '0;
    end else if (w_step) begin
      r_count <= r_count + 1'b1;
    end
  end

  // HI/LO only move on the final iteration; a flush leaves them intact.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_commit) begin
      r_hi <= w_result[2*WIDTH-1:WIDTH];
      r_lo <= w_result[WIDTH-1:0];
    end
  end

  assign busy  = w_run;
  assign stall = w_run & (hilo_rd | start);
  assign done  = (r_state == S_DONE);
  assign hi    = r_hi;
  assign lo    = r_lo;

endmodule

// File: tb/tb_hilo_mult_seq.sv
// Randomized and directed bench for hilo_mult_seq against a
// cycle-count behavioural model using plain 64-bit arithmetic.
module tb_hilo_mult_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sgn;
  logic [31:0] a;
  logic [31:0] b;
  logic        hilo_rd;
  logic        flush;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_chk = 0;
  int n_pass = 0;

  hilo_mult_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .sgn     (sgn),
    .a       (a),
    .b       (b),
    .hilo_rd (hilo_rd),
    .flush   (flush),
    .busy    (busy),
    .stall   (stall),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [63:0] mprod(input logic [31:0] x, input logic [31:0] y, input bit s);
    longint sx, sy;
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    return {32'd0, x} * {32'd0, y};
  endfunction

  // Model: cycles of work left, pending product, committed HI/LO, done flag.
  int          m_left;
  bit          m_done;
  logic [63:0] m_pend;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_left = 0;
      m_done = 0;
      m_hi = '0;
      m_lo = '0;
      m_pend = '0;
    end else if (m_left > 0) begin
      m_done = 0;
      if (flush) m_left = 0;
      else if (m_left == 1) begin
        {m_hi, m_lo} = m_pend;
        m_left = 0;
        m_done = 1;
      end else m_left = m_left - 1;
    end else begin
      m_done = 0;
      if (start && !flush) begin
        m_pend = mprod(a, b, sgn);
        m_left = 32;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", busy, 64'(m_left > 0));
    chk("stall", stall, 64'((m_left > 0) && (hilo_rd || start)));
    chk("done", done, 64'(m_done));
    chk("hi", hi, 64'(m_hi));
    chk("lo", lo, 64'(m_lo));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [31:0] xa, input logic [31:0] xb, input bit s,
                        input logic [31:0] ehi, input logic [31:0] elo, input string nm);
    int cyc;
    start = 1; sgn = s; a = xa; b = xb;
    step();
    start = 0;
    cyc = 0;
    while (!done && cyc < 100) begin
      step();
      cyc++;
    end
    chk({nm, "_latency"}, 64'(cyc), 64'd32);
    chk({nm, "_hi"}, 64'(hi), 64'(ehi));
    chk({nm, "_lo"}, 64'(lo), 64'(elo));
    step();
  endtask

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int cnt;
    int g;
    bit hold;
    rst = 0; start = 0; sgn = 0; a = 0; b = 0; hilo_rd = 0; flush = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    step();
    step();
    rst = 1;
    step();

    chk("pin_3x5", mprod(32'd3, 32'd5, 0), 64'h0000_0000_0000_000F);
    chk("pin_ffu", mprod(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0), 64'hFFFF_FFFE_0000_0001);
    chk("pin_ffs", mprod(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1), 64'h0000_0000_0000_0001);
    chk("pin_m2x3", mprod(32'hFFFF_FFFE, 32'd3, 1), 64'hFFFF_FFFF_FFFF_FFFA);
    chk("pin_min", mprod(32'h8000_0000, 32'h8000_0000, 1), 64'h4000_0000_0000_0000);

    run_op(32'd3, 32'd5, 0, 32'h0, 32'hF, "multu_3x5");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFE, 32'h1, "multu_ff");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'h0, 32'h1, "mult_ff");
    run_op(32'hFFFF_FFFE, 32'd3, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult_m2x3");
    run_op(32'h8000_0000, 32'h8000_0000, 1, 32'h4000_0000, 32'h0, "mult_min");

    // MFHI/MFLO arriving 5 cycles into a multiply
    start = 1; sgn = 0; a = 3; b = 5;
    step();
    start = 0;
    repeat (5) step();
    hilo_rd = 1;
    #1;
    cnt = 0; g = 0;
    while (busy && g < 100) begin
      if (stall) cnt++;
      step();
      g++;
    end
    chk("stall_cycles", 64'(cnt), 64'd27);
    chk("stall_done", done, 1);
    chk("stall_in_done", stall, 0);
    chk("stall_lo", 64'(lo), 64'd15);
    hilo_rd = 0;
    step();

    // flush mid-run keeps prior HI/LO
    start = 1; sgn = 0; a = 7; b = 7;
    step();
    start = 0;
    repeat (10) step();
    flush = 1;
    step();
    flush = 0;
    chk("flush_busy", busy, 0);
    chk("flush_hilo", {hi, lo}, 64'h0000_0000_0000_000F);
    chk("flush_done", done, 0);
    repeat (3) step();

    // async reset mid-run
    start = 1; sgn = 1; a = 9; b = 9;
    step();
    start = 0;
    repeat (10) step();
    #3 rst = 0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_hilo", {hi, lo}, 64'd0);
    step();
    rst = 1;
    step();
    run_op(32'd6, 32'd7, 0, 32'h0, 32'd42, "post_rst");

    for (int i = 0; i < 3000; i++) begin
      hold = (m_left > 0) && start && !flush;
      if (!hold) begin
        start = ($urandom_range(0, 15) == 0);
        sgn = 1'($urandom_range(0, 1));
        a = rand_op();
        b = rand_op();
      end
      hilo_rd = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 63) == 0);
      if (flush) start = 0;
      step();
    end
    start = 0; flush = 0; hilo_rd = 0;
    repeat (40) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
